// File: rtl/des_sbox_sched.sv
// Time-multiplexes one shared DES S-box bank over the eight 6-bit slices of a 48-bit word.
// Optional DES_SBOX_REG_EN: bank is a registered ROM, so each capture trails its address by one cycle.
module des_sbox_sched #(
    parameter int unsigned NUM_BOX = 8,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*NUM_BOX-1:0]   in_data,
    output logic [CNT_W-1:0]       sbox_sel,
    output logic [5:0]             sbox_in,
    input  logic [3:0]             sbox_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NUM_BOX-1:0]   out_data,
    output logic                   busy
);

    localparam int unsigned IN_W  = 6 * NUM_BOX;
    localparam int unsigned OUT_W = 4 * NUM_BOX;
`ifdef DES_SBOX_REG_EN
    // One extra count so the counter can reach NUM_BOX for the trailing capture.
    localparam int unsigned CW = CNT_W + 1;
`else
    localparam int unsigned CW = CNT_W;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]   data_q, data_d;
    logic [OUT_W-1:0]  res_q, res_d;

    logic              issue;
    logic              capture;
    logic              last;
    int                cap_idx;
    logic [5:0]        slice;

`ifdef DES_SBOX_REG_EN
    always_comb begin
        issue   = (state_q == StRun) && (cnt_q < CW'(NUM_BOX));
        capture = (state_q == StRun) && (cnt_q != '0);
        last    = (cnt_q == CW'(NUM_BOX));
        cap_idx = int'(cnt_q) - 1;
    end
`else
    always_comb begin
        issue   = (state_q == StRun);
        capture = (state_q == StRun);
        last    = (cnt_q == CW'(NUM_BOX - 1));
        cap_idx = int'(cnt_q);
    end
`endif

    always_comb begin
        slice = '0;
        for (int k = 0; k < int'(NUM_BOX); k++) begin
            if (int'(cnt_q) == k) begin
                slice = data_q[IN_W-1-6*k -: 6];
            end
        end
    end

    always_comb begin
        sbox_sel = '0;
        sbox_in  = '0;
        if (issue) begin
            sbox_sel = cnt_q[CNT_W-1:0];
            sbox_in  = slice;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (capture) begin
                    for (int k = 0; k < int'(NUM_BOX); k++) begin
                        if (cap_idx == k) begin
                            res_d[OUT_W-1-4*k -: 4] = sbox_out;
                        end
                    end
                end
                if (last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = res_q;

endmodule

// File: tb/tb_des_sbox_sched.sv
// Directed bench for des_sbox_sched with a standard DES S1..S8 bank model.
// Honors DES_SBOX_REG_EN by registering the bank output and stretching expected latency.
module tb_des_sbox_sched;

`ifdef DES_SBOX_REG_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        ident_mode;
    logic [3:0]  bank_comb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    des_sbox_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_sel  (sbox_sel),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [3:0] des_sbox(input logic [2:0] box, input logic [5:0] x);
        logic [255:0] t;
        int idx;
        case (box)
            3'd0: t = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                       64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
            3'd1: t = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                       64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
            3'd2: t = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                       64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
            3'd3: t = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                       64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
            3'd4: t = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                       64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
            3'd5: t = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                       64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
            3'd6: t = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                       64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
            default: t = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
        endcase
        idx = int'({x[5], x[0]}) * 16 + int'(x[4:1]);
        return t[255-4*idx -: 4];
    endfunction

    always_comb bank_comb = ident_mode ? {1'b0, sbox_sel} : des_sbox(sbox_sel, sbox_in);

`ifdef DES_SBOX_REG_EN
    always_ff @(posedge clk) sbox_out <= bank_comb;
`else
    assign sbox_out = bank_comb;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one word, checks every lookup cycle, and stops at the first out_valid cycle.
    task automatic run_word(input string name, input logic [47:0] d, input logic [31:0] exp,
                            input logic rel);
        logic [2:0] exp_sel;
        logic [5:0] exp_in;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = rel;
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        for (int c = 1; c < LAT; c++) begin
            exp_sel = (c <= 8) ? 3'(c - 1) : 3'd0;
            exp_in  = (c <= 8) ? d[47-6*(c-1) -: 6] : 6'd0;
            tests++;
            if (sbox_sel !== exp_sel || sbox_in !== exp_in || out_valid !== 1'b0 ||
                busy !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s_run_c%0d: sel=%0d in=%h ov=%b busy=%b ir=%b, want sel=%0d in=%h ov=0 busy=1 ir=0",
                         name, c, sbox_sel, sbox_in, out_valid, busy, in_ready, exp_sel, exp_in);
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp || sbox_sel !== 3'd0 || sbox_in !== 6'd0) begin
            fails++;
            $display("FAIL %s_result: ov=%b data=%h sel=%0d in=%h, want ov=1 data=%h sel=0 in=00",
                     name, out_valid, out_data, sbox_sel, sbox_in, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        ident_mode = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            sbox_sel !== 3'd0 || sbox_in !== 6'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset: ir=%b ov=%b data=%h sel=%0d in=%h busy=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, sbox_sel, sbox_in, busy);
        end
    endtask

    task automatic test_zero();
        run_word("zero", 48'h0, 32'hEFA72C4D, 1'b1);
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hEFA72C4D) begin
            fails++;
            $display("FAIL zero_release: ov=%b ir=%b data=%h, want ov=0 ir=1 data=efa72c4d",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_ones();
        run_word("ones", 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 1'b1);
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'hD9CE3DCB) begin
            fails++;
            $display("FAIL ones_release: ov=%b busy=%b data=%h, want ov=0 busy=0 data=d9ce3dcb",
                     out_valid, busy, out_data);
        end
    endtask

    task automatic test_hold();
        run_word("hold", 48'h0, 32'hEFA72C4D, 1'b0);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_data  = 48'hFFFF_FFFF_FFFF;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hEFA72C4D || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_c%0d: ov=%b data=%h ir=%b, want ov=1 data=efa72c4d ir=0",
                         i, out_valid, out_data, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 32'hEFA72C4D) begin
            fails++;
            $display("FAIL hold_release: ov=%b busy=%b ir=%b data=%h, want 0 0 1 efa72c4d",
                     out_valid, busy, in_ready, out_data);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 48'h0;
        tick();
        in_data = 48'hFFFF_FFFF_FFFF;
        for (int c = 1; c < LAT; c++) tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hEFA72C4D) begin
            fails++;
            $display("FAIL b2b_first: ov=%b data=%h, want ov=1 data=efa72c4d", out_valid, out_data);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: ir=%b busy=%b, want ir=1 busy=0", in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || sbox_sel !== 3'd0 || sbox_in !== 6'h3F) begin
            fails++;
            $display("FAIL b2b_second_accept: busy=%b ir=%b sel=%0d in=%h, want 1 0 0 3f",
                     busy, in_ready, sbox_sel, sbox_in);
        end
        for (int c = 1; c < LAT; c++) tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hD9CE3DCB) begin
            fails++;
            $display("FAIL b2b_second: ov=%b data=%h, want ov=1 data=d9ce3dcb", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int stale;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 48'h0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sbox_sel !== 3'd0 ||
            sbox_in !== 6'd0 || out_data !== 32'h0) begin
            fails++;
            $display("FAIL midrun_reset: ir=%b busy=%b ov=%b sel=%0d in=%h data=%h, want 1 0 0 0 0 0",
                     in_ready, busy, out_valid, sbox_sel, sbox_in, out_data);
        end
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL midrun_stale: %0d cycles with ov/busy set, want 0", stale);
        end
    endtask

    task automatic test_nibble_order();
        ident_mode = 1'b1;
        run_word("nibble", 48'h1234_5678_9ABC, 32'h01234567, 1'b1);
        tick();
        ident_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_nibble_order();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
